// File: rtl/alu_result_stage.sv
// ALU result stage: captures each accepted ALU result, holds the architectural
// flags, resolves conditional branches against them, and hands results to
// writeback through a 2-entry skid buffer with a registered in_ready.

package alu_result_stage_pkg;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RADDR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_rd_we,
  input  logic             in_flags_we,
  input  logic             in_is_branch,
  input  logic [3:0]       in_cond,
  input  logic [WIDTH-1:0] in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RADDR-1:0] out_rd,
  output logic             out_rd_we,
  output logic [3:0]       flags_q,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RADDR-1:0] rd;
    logic             rd_we;
  } entry_t;

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [3:0]       flags_d;
  logic             br_taken_q, br_taken_d;
  logic [WIDTH-1:0] br_target_q, br_target_d;
  logic             accept;
  entry_t           in_entry;

  // Condition-code evaluation against a flags snapshot
  function automatic logic cond_hit(input alu_flags_t f, input logic [3:0] c);
    logic r;
    r = 1'b0;
    case (c)
      4'h0: r = f.zero;                                  // EQ
      4'h1: r = ~f.zero;                                 // NE
      4'h2: r = f.carry;                                 // CS
      4'h3: r = ~f.carry;                                // CC
      4'h4: r = f.negative;                              // MI
      4'h5: r = ~f.negative;                             // PL
      4'h6: r = f.overflow;                              // VS
      4'h7: r = ~f.overflow;                             // VC
      4'h8: r = f.carry & ~f.zero;                       // HI
      4'h9: r = ~f.carry | f.zero;                       // LS
      4'hA: r = (f.negative == f.overflow);              // GE
      4'hB: r = (f.negative != f.overflow);              // LT
      4'hC: r = ~f.zero & (f.negative == f.overflow);    // GT
      4'hD: r = f.zero | (f.negative != f.overflow);     // LE
      4'hE: r = 1'b1;                                    // AL
      default: r = 1'b0;                                 // NV
    endcase
    return r;
  endfunction

  assign accept   = in_valid & in_ready_q & ~flush;
  assign in_entry = '{result: in_result, rd: in_rd, rd_we: in_rd_we};

  // Next-state: FIFO-ordered main/skid buffer, flags register, branch resolution
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    flags_d      = flags_q;
    br_taken_d   = 1'b0;
    br_target_d  = br_target_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (skid_valid_q && out_ready) begin
        // main drains this cycle; skid moves up so order is preserved
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        if (!main_valid_q || out_ready) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end
      end else if (main_valid_q && out_ready) begin
        main_valid_d = 1'b0;
      end

      if (accept && in_flags_we) begin
        flags_d = in_flags;
      end

      // Branches see the flags as they were before this op's own update
      if (accept && in_is_branch) begin
        br_taken_d  = cond_hit(alu_flags_t'(flags_q), in_cond);
        br_target_d = in_target;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      flags_q      <= 4'h0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      flags_q      <= flags_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_rd_we  = main_q.rd_we;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: drivers push expected writeback
// entries and branch outcomes; a negedge monitor pops and compares.

module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RADDR = 3;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_result, in_target;
  logic [3:0]       in_flags, in_cond;
  logic [RADDR-1:0] in_rd;
  logic             in_rd_we, in_flags_we, in_is_branch;
  logic             out_valid, out_ready, out_rd_we;
  logic [WIDTH-1:0] out_result, br_target;
  logic [RADDR-1:0] out_rd;
  logic [3:0]       flags_q;
  logic             br_taken;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_flags_we(in_flags_we),
    .in_is_branch(in_is_branch), .in_cond(in_cond), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .flags_q(flags_q), .br_taken(br_taken), .br_target(br_target)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [2:0] rd;
    logic       we;
  } dexp_t;

  typedef struct packed {
    logic       taken;
    logic [7:0] tgt;
  } bexp_t;

  dexp_t dq[$];
  bexp_t bq[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: writeback handshakes and branch pulses
  always @(negedge clk) begin
    dexp_t e;
    bexp_t b;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual=0x%0h required=none at %0t", out_result, $time);
        end else begin
          e = dq.pop_front();
          chk("out_result", 32'(out_result), 32'(e.res));
          chk("out_rd",     32'(out_rd),     32'(e.rd));
          chk("out_rd_we",  32'(out_rd_we),  32'(e.we));
        end
      end
      if (bq.size() != 0) begin
        b = bq.pop_front();
        chk("br_taken", 32'(br_taken), 32'(b.taken));
        if (b.taken) chk("br_target", 32'(br_target), 32'(b.tgt));
      end else if (br_taken) begin
        checks++;
        failures++;
        $display("FAIL br_spurious actual=1 required=0 at %0t", $time);
      end
    end
  end

  // Drive one op until accepted; call and return at posedge+1
  task automatic send(input logic [7:0] res, input logic [3:0] fl, input logic [2:0] rd,
                      input logic rd_we, input logic fwe, input logic br,
                      input logic [3:0] cond, input logic [7:0] tgt, input logic exp_taken);
    logic will;
    int   n;
    n            = 0;
    in_result    = res;
    in_flags     = fl;
    in_rd        = rd;
    in_rd_we     = rd_we;
    in_flags_we  = fwe;
    in_is_branch = br;
    in_cond      = cond;
    in_target    = tgt;
    in_valid     = 1'b1;
    forever begin
      @(negedge clk);
      will = in_ready && !flush;
      @(posedge clk);
      #1;
      if (will) begin
        dq.push_back('{res, rd, rd_we});
        if (br) bq.push_back('{exp_taken, tgt});
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 40) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=not_accepted required=accepted res=0x%0h", res);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_result = '0; in_flags = '0; in_rd = '0; in_rd_we = 1'b0;
    in_flags_we = 1'b0; in_is_branch = 1'b0; in_cond = '0; in_target = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_flags",     32'(flags_q),    32'd0);
    chk("rst_br_taken",  32'(br_taken),   32'd0);
    chk("rst_out_result",32'(out_result), 32'd0);
    chk("rst_br_target", 32'(br_target),  32'd0);

    // 2: ADD 0x80 flags {C0,V1,Z0,N1}, then BVS
    send(8'h80, 4'b0101, 3'd1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("flags_add", 32'(flags_q), 32'h5);
    send(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h6, 8'h40, 1'b1);

    // 3: SUB 5-5 flags {C1,V0,Z1,N0}, then BEQ/BNE/BHI
    send(8'h00, 4'b1010, 3'd2, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("flags_sub", 32'(flags_q), 32'hA);
    send(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h10, 1'b1);
    send(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h1, 8'h14, 1'b0);
    send(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h8, 8'h18, 1'b0);

    // 4: branch+flags update in one op uses the old flags
    send(8'h03, 4'b0000, 3'd3, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("flags_clear", 32'(flags_q), 32'h0);
    send(8'h00, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h20, 1'b0);
    chk("flags_same_op", 32'(flags_q), 32'h2);
    send(8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h24, 1'b1);
    idle(3);

    // 5: backpressure fills main+skid, third op waits
    out_ready = 1'b0;
    fork
      begin
        send(8'h11, 4'h0, 3'd4, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        send(8'h22, 4'h0, 3'd5, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        send(8'h33, 4'h0, 3'd6, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end
      begin
        idle(6);
        chk("stall_in_ready",  32'(in_ready),   32'd0);
        chk("stall_out_valid", 32'(out_valid),  32'd1);
        chk("stall_out_hold",  32'(out_result), 32'h11);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("recover_in_ready", 32'(in_ready), 32'd1);

    // 6: flush with skid full and a live input
    out_ready = 1'b0;
    send(8'hA1, 4'h0, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'hB2, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_result = 8'h77; in_flags = 4'hF; in_flags_we = 1'b1;
    in_is_branch = 1'b1; in_cond = 4'hE; in_target = 8'h99;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    dq.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    chk("flush_flags",     32'(flags_q),   32'h2);

    // Post-flush traffic flows normally
    out_ready = 1'b1;
    send(8'h5A, 4'h0, 3'd7, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 20 && dq.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_empty", 32'(dq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
